mbist_march_gen: RTL and testbench

March-sequence generator on the stimulus side of the MBIST engine. It takes march-element descriptors through a valid/ready handshake and walks the test address range up or down. At each address it issues the element's read/write operations to the memory port. It also drives the compare-side strobes (compare, comp_data, read_invert, addr, addr_inc_phase), aligned with the one-cycle memory read latency.

---
 rtl/mbist_march_gen_if.sv | 41 ++++
 rtl/mbist_march_gen.sv | 157 +++++++++++++++
 tb/tb_mbist_march_gen.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mbist_march_gen_if.sv
// Port bundle for mbist_march_gen: test control, march-element descriptor handshake,
// memory stimulus port and the compare-side strobes.
interface mbist_march_gen_if #(
    parameter int ADDR_WD = 9,
    parameter int DATA_WD = 32
);
    logic               start;
    logic [1:0]         pat_sel;
    logic               elem_valid;
    logic               elem_ready;
    logic               elem_dir;
    logic [1:0]         elem_len;
    logic [3:0]         elem_wr;
    logic [3:0]         elem_inv;
    logic               elem_last;
    logic               abort;
    logic               mem_cs;
    logic               mem_we;
    logic [ADDR_WD-1:0] mem_addr;
    logic [DATA_WD-1:0] mem_wdata;
    logic               compare;
    logic [DATA_WD-1:0] comp_data;
    logic               read_invert;
    logic [ADDR_WD-1:0] addr;
    logic               addr_inc_phase;
    logic               busy;
    logic               done;
    logic               fail;

    modport master (
        input  start, pat_sel, elem_valid, elem_dir, elem_len, elem_wr, elem_inv, elem_last, abort,
        output elem_ready, mem_cs, mem_we, mem_addr, mem_wdata, compare, comp_data, read_invert,
               addr, addr_inc_phase, busy, done, fail
    );

    modport slave (
        output start, pat_sel, elem_valid, elem_dir, elem_len, elem_wr, elem_inv, elem_last, abort,
        input  elem_ready, mem_cs, mem_we, mem_addr, mem_wdata, compare, comp_data, read_invert,
               addr, addr_inc_phase, busy, done, fail
    );
endinterface

// File: rtl/mbist_march_gen.sv
// March-sequence generator: one memory op per cycle, compare strobes one cycle after each read.
// Optional MBIST_CHECKERBOARD_EN: background pattern inverted at odd addresses.
module mbist_march_gen #(
    parameter int                      BIST_ADDR_WD    = 9,
    parameter int                      BIST_DATA_WD    = 32,
    parameter logic [BIST_ADDR_WD-1:0] BIST_ADDR_START = 9'h000,
    parameter logic [BIST_ADDR_WD-1:0] BIST_ADDR_END   = 9'h1F8
) (
    input  logic              clk,
    input  logic              rst_n,
    mbist_march_gen_if.master bus
);
    typedef enum logic [2:0] {IDLE, FETCH, RUN, DRAIN, DONE} state_t;

    state_t                  state, state_nxt;
    logic [1:0]              pat;
    logic [BIST_ADDR_WD-1:0] cur_addr;
    logic [1:0]              op_idx;
    logic                    e_dir;
    logic [1:0]              e_len;
    logic [3:0]              e_wr;
    logic [3:0]              e_inv;
    logic                    e_last;
    logic                    fail_q;

    logic                    rd_vld;
    logic                    rd_inv;
    logic [BIST_DATA_WD-1:0] rd_bg;
    logic [BIST_ADDR_WD-1:0] rd_addr;

    logic [7:0]              pat_byte;
    logic [BIST_DATA_WD-1:0] bg;
    logic                    odd;
    logic                    run;
    logic                    op_wr;
    logic                    op_inv;
    logic                    op_last;
    logic                    addr_last;
    logic                    run_rd;

    always_comb begin
        pat_byte = 8'h00;
        case (pat)
            2'd1:    pat_byte = 8'h55;
            2'd2:    pat_byte = 8'h33;
            2'd3:    pat_byte = 8'h0F;
            default: pat_byte = 8'h00;
        endcase
    end

`ifdef MBIST_CHECKERBOARD_EN
    assign odd = cur_addr[0];
`else
    assign odd = 1'b0;
`endif

    for (genvar g = 0; g < BIST_DATA_WD; g++) begin : g_bg
        assign bg[g] = pat_byte[g % 8] ^ odd;
    end

    assign run       = (state == RUN);
    assign op_wr     = e_wr[op_idx];
    assign op_inv    = e_inv[op_idx];
    assign op_last   = (op_idx == e_len);
    assign addr_last = (cur_addr == (e_dir ? BIST_ADDR_START : BIST_ADDR_END));
    assign run_rd    = run && !op_wr;

    always_comb begin
        state_nxt          = state;
        bus.elem_ready     = (state == FETCH);
        bus.mem_cs         = run;
        bus.mem_we         = run && op_wr;
        bus.mem_addr       = run ? cur_addr : '0;
        bus.mem_wdata      = run ? (bg ^ {BIST_DATA_WD{op_inv}}) : '0;
        bus.addr_inc_phase = run && op_last;
        bus.compare        = rd_vld;
        bus.comp_data      = rd_bg;
        bus.read_invert    = rd_inv;
        bus.addr           = rd_addr;
        bus.busy           = (state inside {FETCH, RUN, DRAIN});
        bus.done           = (state == DONE);
        bus.fail           = fail_q;
        case (state)
            IDLE:  if (bus.start) state_nxt = FETCH;
            FETCH: begin
                if (bus.abort)           state_nxt = DONE;
                else if (bus.elem_valid) state_nxt = RUN;
            end
            RUN: begin
                // the op shown this cycle is always issued; a read still needs its compare slot
                if (bus.abort || (op_last && addr_last && e_last))
                    state_nxt = op_wr ? DONE : DRAIN;
                else if (op_last && addr_last)
                    state_nxt = FETCH;
            end
            DRAIN:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            pat      <= '0;
            cur_addr <= '0;
            op_idx   <= '0;
            e_dir    <= 1'b0;
            e_len    <= '0;
            e_wr     <= '0;
            e_inv    <= '0;
            e_last   <= 1'b0;
            fail_q   <= 1'b0;
            rd_vld   <= 1'b0;
            rd_inv   <= 1'b0;
            rd_bg    <= '0;
            rd_addr  <= '0;
        end else begin
            state   <= state_nxt;
            rd_vld  <= run_rd;
            rd_inv  <= run_rd && op_inv;
            rd_bg   <= run_rd ? bg : '0;
            rd_addr <= run_rd ? cur_addr : '0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        fail_q <= 1'b0;
                        pat    <= bus.pat_sel;
                    end
                end
                FETCH: begin
                    if (bus.abort) begin
                        fail_q <= 1'b1;
                    end else if (bus.elem_valid) begin
                        e_dir    <= bus.elem_dir;
                        e_len    <= bus.elem_len;
                        e_wr     <= bus.elem_wr;
                        e_inv    <= bus.elem_inv;
                        e_last   <= bus.elem_last;
                        cur_addr <= bus.elem_dir ? BIST_ADDR_END : BIST_ADDR_START;
                        op_idx   <= '0;
                    end
                end
                RUN: begin
                    if (bus.abort) fail_q <= 1'b1;
                    if (op_last) begin
                        op_idx <= '0;
                        if (!addr_last) cur_addr <= e_dir ? cur_addr - 1'b1 : cur_addr + 1'b1;
                    end else begin
                        op_idx <= op_idx + 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mbist_march_gen.sv
// Bench for mbist_march_gen: a cycle-accurate expected trace is generated from the element list
// with plain loops, then compared against the DUT cycle by cycle.
module tb_mbist_march_gen;
    localparam int AW = 9;
    localparam int DW = 32;
    localparam logic [AW-1:0] S0 = 9'h000;
    localparam logic [AW-1:0] E0 = 9'h1F8;
    localparam logic [AW-1:0] S1 = 9'h005;
    localparam logic [AW-1:0] E1 = 9'h005;
`ifdef MBIST_CHECKERBOARD_EN
    localparam bit CB = 1'b1;
`else
    localparam bit CB = 1'b0;
`endif

    typedef struct packed {
        logic          cs;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic          aip;
        logic          cmp;
        logic [DW-1:0] cdata;
        logic          cinv;
        logic [AW-1:0] caddr;
        logic          rdy;
        logic          busy;
        logic          done;
        logic          fail;
    } obs_t;

    typedef struct packed {
        logic       dir;
        logic [1:0] len;
        logic [3:0] wr;
        logic [3:0] inv;
        logic       last;
    } el_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sel;
    logic       start;
    logic [1:0] pat_sel;
    logic       elem_valid;
    logic       elem_dir;
    logic [1:0] elem_len;
    logic [3:0] elem_wr;
    logic [3:0] elem_inv;
    logic       elem_last;
    logic       abort;

    always #5 clk = ~clk;

    mbist_march_gen_if #(.ADDR_WD(AW), .DATA_WD(DW)) b0 ();
    mbist_march_gen_if #(.ADDR_WD(AW), .DATA_WD(DW)) b1 ();

    assign b0.start      = start & ~sel;
    assign b1.start      = start & sel;
    assign b0.pat_sel    = pat_sel;
    assign b1.pat_sel    = pat_sel;
    assign b0.elem_valid = elem_valid;
    assign b1.elem_valid = elem_valid;
    assign b0.elem_dir   = elem_dir;
    assign b1.elem_dir   = elem_dir;
    assign b0.elem_len   = elem_len;
    assign b1.elem_len   = elem_len;
    assign b0.elem_wr    = elem_wr;
    assign b1.elem_wr    = elem_wr;
    assign b0.elem_inv   = elem_inv;
    assign b1.elem_inv   = elem_inv;
    assign b0.elem_last  = elem_last;
    assign b1.elem_last  = elem_last;
    assign b0.abort      = abort;
    assign b1.abort      = abort;

    mbist_march_gen #(.BIST_ADDR_WD(AW), .BIST_DATA_WD(DW), .BIST_ADDR_START(S0), .BIST_ADDR_END(E0))
        dut0 (.clk(clk), .rst_n(rst_n), .bus(b0.master));
    mbist_march_gen #(.BIST_ADDR_WD(AW), .BIST_DATA_WD(DW), .BIST_ADDR_START(S1), .BIST_ADDR_END(E1))
        dut1 (.clk(clk), .rst_n(rst_n), .bus(b1.master));

    obs_t o0, o1, o;
    assign o0 = {b0.mem_cs, b0.mem_we, b0.mem_addr, b0.mem_wdata, b0.addr_inc_phase, b0.compare,
                 b0.comp_data, b0.read_invert, b0.addr, b0.elem_ready, b0.busy, b0.done, b0.fail};
    assign o1 = {b1.mem_cs, b1.mem_we, b1.mem_addr, b1.mem_wdata, b1.addr_inc_phase, b1.compare,
                 b1.comp_data, b1.read_invert, b1.addr, b1.elem_ready, b1.busy, b1.done, b1.fail};
    assign o  = sel ? o1 : o0;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    el_t  els[$];
    obs_t tr[$];
    int   n_act;
    bit   pend;
    obs_t pc;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] bgv(input logic [1:0] p, input logic [AW-1:0] a);
        logic [7:0]    b;
        logic [DW-1:0] v;
        b = (p == 2'd0) ? 8'h00 : (p == 2'd1) ? 8'h55 : (p == 2'd2) ? 8'h33 : 8'h0F;
        v = {4{b}};
        if (CB && a[0]) v = ~v;
        return v;
    endfunction

    // a read issued in the previous expected cycle shows up as this cycle's compare
    task automatic attach(inout obs_t r);
        if (pend) begin
            r.cmp   = 1'b1;
            r.cdata = pc.cdata;
            r.cinv  = pc.cinv;
            r.caddr = pc.caddr;
        end
        pend = 1'b0;
    endtask

    task automatic build(input logic [1:0] p, input logic [AW-1:0] s, input logic [AW-1:0] e,
                         input int abort_at);
        obs_t          r;
        bit            stop;
        int            n;
        logic [AW-1:0] a;
        tr.delete();
        pend = 1'b0;
        stop = 1'b0;
        n    = int'(e) - int'(s) + 1;
        foreach (els[k]) begin
            if (!stop) begin
                r = '0; r.busy = 1'b1; r.rdy = 1'b1;
                attach(r);
                tr.push_back(r);
                stop = (tr.size() - 1 == abort_at);
            end
            for (int j = 0; j < n && !stop; j++) begin
                a = els[k].dir ? e - AW'(j) : s + AW'(j);
                for (int op = 0; op <= int'(els[k].len) && !stop; op++) begin
                    r = '0; r.busy = 1'b1; r.cs = 1'b1; r.we = els[k].wr[op]; r.addr = a;
                    r.wdata = bgv(p, a) ^ {DW{els[k].inv[op]}};
                    r.aip   = (op == int'(els[k].len));
                    attach(r);
                    pend     = !r.we;
                    pc.cdata = bgv(p, a);
                    pc.cinv  = els[k].inv[op];
                    pc.caddr = a;
                    tr.push_back(r);
                    stop = (tr.size() - 1 == abort_at);
                end
            end
        end
        n_act = tr.size();
        if (pend) begin
            r = '0; r.busy = 1'b1;
            attach(r);
            tr.push_back(r);
        end
        r = '0; r.done = 1'b1;
        tr.push_back(r);
    endtask

    task automatic present(input int k);
        if (k < els.size()) begin
            elem_valid = 1'b1; elem_dir = els[k].dir; elem_len = els[k].len;
            elem_wr = els[k].wr; elem_inv = els[k].inv; elem_last = els[k].last;
        end else begin
            elem_valid = 1'b0; elem_dir = 1'b0; elem_len = '0;
            elem_wr = '0; elem_inv = '0; elem_last = 1'b0;
        end
    endtask

    task automatic cmp_rec(input obs_t r);
        chk("cs", 64'(o.cs), 64'(r.cs));
        chk("busy", 64'(o.busy), 64'(r.busy));
        chk("done", 64'(o.done), 64'(r.done));
        chk("ready", 64'(o.rdy), 64'(r.rdy));
        chk("inc_phase", 64'(o.aip), 64'(r.aip));
        chk("compare", 64'(o.cmp), 64'(r.cmp));
        if (r.cs) begin
            chk("we", 64'(o.we), 64'(r.we));
            chk("mem_addr", 64'(o.addr), 64'(r.addr));
            if (r.we) chk("wdata", 64'(o.wdata), 64'(r.wdata));
        end
        if (r.cmp) begin
            chk("comp_data", 64'(o.cdata), 64'(r.cdata));
            chk("read_inv", 64'(o.cinv), 64'(r.cinv));
            chk("cmp_addr", 64'(o.caddr), 64'(r.caddr));
        end
    endtask

    // cut >= 0 stops after that many expected cycles, leaving the DUT mid-test
    task automatic run(input bit s_sel, input logic [1:0] p, input int abort_at,
                       input int mid_start, input int cut);
        int nxt;
        nxt = 0;
        sel = s_sel;
        build(p, s_sel ? S1 : S0, s_sel ? E1 : E0, abort_at);
        @(posedge clk); #1;
        start = 1'b1; pat_sel = p; abort = 1'b0;
        present(0);
        @(posedge clk); #1;
        for (int i = 0; i < tr.size() && i != cut; i++) begin
            start   = (i == mid_start);
            abort   = (i == abort_at);
            pat_sel = 2'($urandom);
            present(nxt);
            #1;
            cyc++;
            cmp_rec(tr[i]);
            if (o.rdy && elem_valid) nxt++;
            @(posedge clk); #1;
        end
        if (cut < 0) begin
            start = 1'b0; abort = 1'b0; elem_valid = 1'b0;
            #1;
            cyc++;
            chk("idle_busy", 64'(o.busy), 64'd0);
            chk("idle_cs", 64'(o.cs), 64'd0);
            chk("idle_done", 64'(o.done), 64'd0);
            chk("fail", 64'(o.fail), (abort_at >= 0) ? 64'd1 : 64'd0);
        end
    endtask

    task automatic add_el(input logic dir, input logic [1:0] len, input logic [3:0] wr,
                          input logic [3:0] inv, input logic last);
        el_t e;
        e.dir = dir; e.len = len; e.wr = wr; e.inv = inv; e.last = last;
        els.push_back(e);
    endtask

    task automatic rand_els(input int n);
        els.delete();
        for (int k = 0; k < n; k++)
            add_el(1'($urandom), 2'($urandom), 4'($urandom), 4'($urandom), k == n - 1);
    endtask

    task automatic rand_test(input bit s_sel, input int n_el);
        logic [1:0] p;
        int         ab;
        int         ms;
        rand_els(n_el);
        p = 2'($urandom);
        build(p, s_sel ? S1 : S0, s_sel ? E1 : E0, -1);
        ab = ($urandom_range(0, 1) == 1) ? $urandom_range(0, n_act - 1) : -1;
        ms = $urandom_range(0, n_act - 1);
        run(s_sel, p, ab, ms, -1);
    endtask

    initial begin
        rst_n = 1'b0; sel = 1'b0; start = 1'b0; pat_sel = '0; abort = 1'b0;
        present(0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cs0", 64'(o0.cs), 64'd0);
        chk("rst_busy0", 64'(o0.busy), 64'd0);
        chk("rst_cmp0", 64'(o0.cmp), 64'd0);
        chk("rst_fail0", 64'(o0.fail), 64'd0);
        chk("rst_done1", 64'(o1.done), 64'd0);
        chk("rst_ready1", 64'(o1.rdy), 64'd0);
        rst_n = 1'b1;

        els.delete(); add_el(1'b0, 2'd0, 4'b0001, 4'b0000, 1'b1);
        run(1'b0, 2'd1, -1, -1, -1);

        els.delete();
        add_el(1'b0, 2'd0, 4'b0001, 4'b0000, 1'b0);
        add_el(1'b0, 2'd1, 4'b0010, 4'b0010, 1'b0);
        add_el(1'b1, 2'd0, 4'b0000, 4'b0001, 1'b1);
        run(1'b0, 2'd1, -1, -1, -1);

        // expected cycle 17 is the read at 0x010, so abort lands on the next read
        els.delete(); add_el(1'b0, 2'd0, 4'b0000, 4'b0000, 1'b1);
        run(1'b0, 2'd2, 18, 5, -1);

        els.delete(); add_el(1'b0, 2'd1, 4'b0001, 4'b0000, 1'b1);
        run(1'b0, 2'd0, -1, -1, -1);

        els.delete();
        add_el(1'b0, 2'd3, 4'b0101, 4'b0011, 1'b0);
        add_el(1'b1, 2'd1, 4'b0010, 4'b0001, 1'b1);
        run(1'b1, 2'd3, -1, -1, -1);

        for (int t = 0; t < 6; t++) rand_test(1'b0, $urandom_range(1, 2));
        for (int t = 0; t < 6; t++) rand_test(1'b1, $urandom_range(1, 3));

        els.delete(); add_el(1'b0, 2'd1, 4'b0001, 4'b0000, 1'b1);
        run(1'b0, 2'd1, -1, -1, 300);
        #2;
        rst_n = 1'b0;
        #1;
        cyc++;
        chk("mid_rst_cs", 64'(o0.cs), 64'd0);
        chk("mid_rst_we", 64'(o0.we), 64'd0);
        chk("mid_rst_wdata", 64'(o0.wdata), 64'd0);
        chk("mid_rst_addr", 64'(o0.addr), 64'd0);
        chk("mid_rst_cmp", 64'(o0.cmp), 64'd0);
        chk("mid_rst_busy", 64'(o0.busy), 64'd0);
        chk("mid_rst_aip", 64'(o0.aip), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        rand_test(1'b0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
